// File: rtl/usb_speed_autodetect_pkg.sv
// Shared USB speed codes, line-state encodings and detector state type
// used by the speed auto-detector and its bench.
package usb_defines;

  localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
  localparam logic [1:0] USB_SPEED_LS   = 2'd1;
  localparam logic [1:0] USB_SPEED_FS   = 2'd2;
  localparam logic [1:0] USB_SPEED_HS   = 2'd3;

  // Line state is {D-, D+}: D- high is the low-speed J, D+ high is the full-speed J
  localparam logic [1:0] LINE_SE0  = 2'b00;
  localparam logic [1:0] LINE_J_FS = 2'b01;
  localparam logic [1:0] LINE_J_LS = 2'b10;

  typedef enum logic [2:0] {
    START,
    IDLE,
    HIGH_LS,
    HIGH_FS,
    LOW,
    DONE
  } usb_detect_state_t;

endpackage

// File: rtl/usb_speed_autodetect_if.sv
// Front-end line state, detection control and detected-speed result
// bundled between the PHY front end and the capture/trigger logic.
interface usb_speed_autodetect_if #(
  parameter int pCOUNTER_WIDTH = 24
);

  logic                      fe_linestate0;
  logic                      fe_linestate1;
  logic                      I_restart;
  logic [pCOUNTER_WIDTH-1:0] I_wait1;
  logic [pCOUNTER_WIDTH-1:0] I_wait2;
  logic [1:0]                O_speed;

  modport master (
    output fe_linestate0,
    output fe_linestate1,
    output I_restart,
    output I_wait1,
    output I_wait2,
    input  O_speed
  );

  modport slave (
    input  fe_linestate0,
    input  fe_linestate1,
    input  I_restart,
    input  I_wait1,
    input  I_wait2,
    output O_speed
  );

endinterface

// File: rtl/usb_speed_autodetect.sv
// Classifies the attached USB device as LS/FS/HS from J-state polarity and
// HS chirp-low duration after a bus reset; result latched until restart.
module usb_speed_autodetect
  import usb_defines::*;
#(
  parameter int pCOUNTER_WIDTH   = 24,
  parameter int pWAIT_0_START    = 8,
  parameter int pWAIT_1_LINEHIGH = 32,
  parameter int pWAIT_2_LINELOW  = 32
) (
  input  logic                   fe_clk,
  input  logic                   reset_n,
  usb_speed_autodetect_if.slave  bus
);

  localparam logic [pCOUNTER_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [pCOUNTER_WIDTH-1:0] CNT_ONE    = pCOUNTER_WIDTH'(1);
  localparam logic [pCOUNTER_WIDTH-1:0] START_LAST = pCOUNTER_WIDTH'(pWAIT_0_START - 1);

  usb_detect_state_t         state, state_next;
  logic [pCOUNTER_WIDTH-1:0] cnt, cnt_next, cnt_inc;
  logic [1:0]                speed, speed_next;
  logic [1:0]                ls;
  logic [pCOUNTER_WIDTH-1:0] w1, w2;
  logic                      j_done, low_done;

  assign ls = {bus.fe_linestate1, bus.fe_linestate0};
  assign w1 = (bus.I_wait1 == '0) ? pCOUNTER_WIDTH'(pWAIT_1_LINEHIGH) : bus.I_wait1;
  assign w2 = (bus.I_wait2 == '0) ? pCOUNTER_WIDTH'(pWAIT_2_LINELOW) : bus.I_wait2;

  // Saturating increment so a stuck line can never wrap the count back to zero
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // The IDLE cycle that spotted the J is the first J cycle, so the counter
  // (cleared on entry) lags the true J run length by one.
  assign j_done   = (cnt_inc >= (w1 - CNT_ONE));
  assign low_done = (cnt_inc >= w2);

  // State, counter and result registers
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= START;
      cnt   <= '0;
      speed <= USB_SPEED_AUTO;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      speed <= speed_next;
    end
  end

  // Next-state, counter and speed decisions; restart overrides everything
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    speed_next = speed;
    if (bus.I_restart) begin
      state_next = START;
      cnt_next   = '0;
      speed_next = USB_SPEED_AUTO;
    end else begin
      case (state)
        START: begin
          if (cnt >= START_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        IDLE: begin
          if (ls == LINE_J_LS) begin
            state_next = HIGH_LS;
            cnt_next   = '0;
          end else if (ls == LINE_J_FS) begin
            state_next = HIGH_FS;
            cnt_next   = '0;
          end
        end
        HIGH_LS: begin
          if (ls == LINE_J_LS) begin
            if (j_done) begin
              state_next = DONE;
              speed_next = USB_SPEED_LS;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        HIGH_FS: begin
          if (ls == LINE_J_FS) begin
            if (j_done) begin
              state_next = LOW;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        LOW: begin
          // J may still be on the line when the minimum J time is met;
          // keep waiting until the chirp-low actually starts.
          if (ls == LINE_SE0) begin
            if (low_done) begin
              state_next = DONE;
              speed_next = USB_SPEED_HS;
            end else begin
              cnt_next = cnt_inc;
            end
          end else if ((ls == LINE_J_FS) && (cnt == '0)) begin
            state_next = LOW;
          end else begin
            state_next = DONE;
            speed_next = USB_SPEED_FS;
          end
        end
        DONE: begin
          state_next = DONE;
        end
        default: begin
          state_next = START;
          cnt_next   = '0;
          speed_next = USB_SPEED_AUTO;
        end
      endcase
    end
  end

  assign bus.O_speed = speed;

endmodule

// File: tb/tb_usb_speed_autodetect.sv
// Bench for usb_speed_autodetect: directed line-state scenarios plus random
// run-length sequences judged by a run-based reference model.
module tb_usb_speed_autodetect;
  import usb_defines::*;

  localparam int W = 24;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b1;

  int checkCount = 0;
  int errorCount = 0;

  logic [1:0] stimSeq[$];

  usb_speed_autodetect_if #(.pCOUNTER_WIDTH(W)) bus ();

  usb_speed_autodetect #(
    .pCOUNTER_WIDTH   (W),
    .pWAIT_0_START    (8),
    .pWAIT_1_LINEHIGH (32),
    .pWAIT_2_LINELOW  (32)
  ) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void addRun(input logic [1:0] v, input int n);
    for (int k = 0; k < n; k++) stimSeq.push_back(v);
  endfunction

  // Reference: walk the per-cycle line-state list as runs of equal values
  function automatic logic [1:0] predict(input logic [1:0] seq[$], input int unsigned w1Raw, input int unsigned w2Raw);
    int need;
    int lowNeed;
    int i;
    int n;
    int r;
    int p;
    int lowLen;
    logic [1:0] v;
    need    = (w1Raw == 0) ? 32 : int'(w1Raw);
    if (need < 2) need = 2;
    lowNeed = (w2Raw == 0) ? 32 : int'(w2Raw);
    n = seq.size();
    i = 8;
    while (i < n) begin
      if (seq[i] != 2'b10 && seq[i] != 2'b01) begin
        i++;
        continue;
      end
      v = seq[i];
      r = 0;
      while (i + r < n && seq[i + r] == v) r++;
      if (r < need) begin
        i = i + r + 1;
        continue;
      end
      if (v == 2'b10) return USB_SPEED_LS;
      p = i + r;
      lowLen = 0;
      while (p + lowLen < n && seq[p + lowLen] == 2'b00) lowLen++;
      if (lowLen >= lowNeed) return USB_SPEED_HS;
      if (p + lowLen >= n) return USB_SPEED_AUTO;
      return USB_SPEED_FS;
    end
    return USB_SPEED_AUTO;
  endfunction

  task automatic driveSeq();
    foreach (stimSeq[k]) begin
      {bus.fe_linestate1, bus.fe_linestate0} = stimSeq[k];
      @(negedge fe_clk);
    end
  endtask

  task automatic applyStimulus(input int unsigned w1, input int unsigned w2);
    @(negedge fe_clk);
    bus.I_wait1   = W'(w1);
    bus.I_wait2   = W'(w2);
    bus.I_restart = 1'b1;
    @(negedge fe_clk);
    checkOutput("restart_clear", bus.O_speed, USB_SPEED_AUTO);
    bus.I_restart = 1'b0;
    driveSeq();
  endtask

  task automatic runDirected(input string tag, input int unsigned w1, input int unsigned w2, input logic [1:0] expected);
    applyStimulus(w1, w2);
    checkOutput(tag, bus.O_speed, expected);
  endtask

  task automatic holdCheck(input string tag, input int n, input logic [1:0] expected);
    for (int k = 0; k < n; k++) begin
      {bus.fe_linestate1, bus.fe_linestate0} = 2'($urandom_range(0, 3));
      @(negedge fe_clk);
    end
    checkOutput(tag, bus.O_speed, expected);
  endtask

  task automatic runRandom(input int iters);
    int unsigned w1;
    int unsigned w2;
    int segs;
    int pick;
    logic [1:0] v;
    logic [1:0] expected;
    for (int t = 0; t < iters; t++) begin
      w1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      w2 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
      stimSeq.delete();
      for (int k = 0; k < 8; k++) stimSeq.push_back(2'($urandom_range(0, 3)));
      addRun(2'b00, $urandom_range(0, 3));
      segs = $urandom_range(1, 5);
      for (int s = 0; s < segs; s++) begin
        pick = $urandom_range(0, 9);
        if (pick < 4) v = 2'b01;
        else if (pick < 7) v = 2'b10;
        else if (pick < 9) v = 2'b00;
        else v = 2'b11;
        addRun(v, $urandom_range(1, 36));
      end
      expected = predict(stimSeq, w1, w2);
      applyStimulus(w1, w2);
      checkOutput($sformatf("random_%0d_w1_%0d_w2_%0d", t, w1, w2), bus.O_speed, expected);
    end
  endtask

  initial begin
    bus.fe_linestate0 = 1'b0;
    bus.fe_linestate1 = 1'b0;
    bus.I_restart     = 1'b0;
    bus.I_wait1       = W'(32);
    bus.I_wait2       = W'(32);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_state", bus.O_speed, USB_SPEED_AUTO);
    repeat (2) @(negedge fe_clk);
    reset_n = 1'b1;

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b10, 10); addRun(2'b00, 3);
    runDirected("early_abort_ls", 32, 32, USB_SPEED_AUTO);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b10, 34); addRun(2'b00, 3);
    runDirected("ls_detect", 32, 32, USB_SPEED_LS);
    holdCheck("ls_hold", 20, USB_SPEED_LS);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b01, 34); addRun(2'b00, 31); addRun(2'b01, 4);
    runDirected("fs_w2_minus_1", 32, 32, USB_SPEED_FS);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b01, 34); addRun(2'b00, 32); addRun(2'b01, 4);
    runDirected("hs_exact_w2", 32, 32, USB_SPEED_HS);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b01, 34); addRun(2'b00, 40);
    runDirected("hs_no_release", 32, 32, USB_SPEED_HS);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b01, 34); addRun(2'b00, 34); addRun(2'b01, 4);
    runDirected("hs_detect", 32, 32, USB_SPEED_HS);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset_done", bus.O_speed, USB_SPEED_AUTO);
    @(negedge fe_clk);
    reset_n = 1'b1;

    // Line is ignored during the start window after restart
    stimSeq.delete(); addRun(2'b00, 5); addRun(2'b10, 5); addRun(2'b00, 3);
    runDirected("start_ignore_short", 5, 32, USB_SPEED_AUTO);
    stimSeq.delete(); addRun(2'b00, 8); addRun(2'b10, 5); addRun(2'b00, 3);
    runDirected("start_window_end", 5, 32, USB_SPEED_LS);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b10, 4); addRun(2'b00, 3);
    runDirected("wait1_5_short", 5, 32, USB_SPEED_AUTO);
    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b10, 31); addRun(2'b00, 3);
    runDirected("wait1_default_short", 0, 0, USB_SPEED_AUTO);
    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b10, 32); addRun(2'b00, 3);
    runDirected("wait1_default_exact", 0, 0, USB_SPEED_LS);

    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b01, 10); addRun(2'b11, 1); addRun(2'b01, 10); addRun(2'b00, 10);
    runDirected("se1_abort_fs", 5, 32, USB_SPEED_FS);

    // Reset in the middle of a J run must discard the J already counted
    stimSeq.delete(); addRun(2'b00, 10); addRun(2'b01, 15);
    applyStimulus(32, 32);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_mid_high_fs", bus.O_speed, USB_SPEED_AUTO);
    @(negedge fe_clk);
    reset_n = 1'b1;
    stimSeq.delete(); addRun(2'b01, 20); addRun(2'b00, 34);
    driveSeq();
    checkOutput("reset_discards_j", bus.O_speed, USB_SPEED_AUTO);

    runRandom(40);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/usb_speed_autodetect.md
Name: usb_speed_autodetect

Overview:
Watches the USB front-end PHY line state after a bus reset and classifies the attached device as low-, full- or high-speed. It uses the J-state polarity and the duration of the high-speed chirp. Sits between the front-end line-state inputs and the capture/trigger logic, which needs the detected speed. The result is latched until restart or reset. All logic runs in the fe_clk domain.

Parameters:
- pCOUNTER_WIDTH, 24, width of duration counter and of I_wait1/I_wait2.
- pWAIT_0_START, 8, fe_clk cycles ignored after reset/restart before line state is examined.
- pWAIT_1_LINEHIGH, 32, fallback minimum J duration used when I_wait1 == 0.
- pWAIT_2_LINELOW, 32, fallback HS chirp-low threshold used when I_wait2 == 0.

Ports:
- fe_clk, in, 1, sole clock; all inputs are synchronous to it.
- reset_n, in, 1, asynchronous active-low reset.
- fe_linestate0, in, 1, D+ line state (1 = high).
- fe_linestate1, in, 1, D- line state (1 = high).
- I_restart, in, 1, level; while high, hold in START and force speed AUTO; detection begins when it deasserts.
- I_wait1, in, pCOUNTER_WIDTH, required consecutive J cycles.
- I_wait2, in, pCOUNTER_WIDTH, low-phase cycles at or above which HS is declared.
- O_speed, out, 2, detected speed (AUTO/LS/FS/HS encoding).

Behaviour:
- Reset and restart values:
  - reset_n low: state=START, counter=0, O_speed=AUTO.
  - I_restart high: same as reset, applied synchronously.
- Effective thresholds: W1 = (I_wait1==0) ? pWAIT_1_LINEHIGH : I_wait1. W2 is defined the same way from I_wait2 and pWAIT_2_LINELOW.
- Line state is ls = {fe_linestate1, fe_linestate0}.
- States:
  - START: count pWAIT_0_START cycles while ignoring ls, then go to IDLE.
  - IDLE: on ls=10 go to HIGH_LS; on ls=01 go to HIGH_FS. Clear the counter on either transition. Otherwise stay.
  - HIGH_LS: counter++ while ls==10.
    - When counter reaches W1 (W1 consecutive cycles): O_speed=LS, go to DONE.
    - If ls!=10 earlier: abort to IDLE, O_speed stays AUTO.
  - HIGH_FS: counter++ while ls==01.
    - When counter reaches W1: clear the counter, go to LOW.
    - If ls!=01 earlier: abort to IDLE, O_speed AUTO.
  - LOW: counter++ while ls==00.
    - When counter reaches W2: O_speed=HS, go to DONE.
    - If ls!=00 before that: O_speed=FS, go to DONE.
  - DONE: hold O_speed until restart or reset. Ignore ls.
- O_speed is registered and updates one fe_clk cycle after the qualifying edge/count.
- The counter saturates at all-ones and never wraps.
- Comparisons are unsigned.
- SE1 (ls=11) counts as "not the expected state" in every phase.
- Restart has priority over all state transitions in the same cycle.
- Reset asserted mid-detection abandons detection immediately and sets O_speed to AUTO.
- Boundaries:
  - LOW exited with exactly W2-1 low cycles → FS.
  - LOW reaching W2 low cycles → HS, even if ls never goes high again.

Decomposition:
- Shared package (usb_defines):
  - USB_SPEED_AUTO=2'd0, USB_SPEED_LS=2'd1, USB_SPEED_FS=2'd2, USB_SPEED_HS=2'd3.
  - state enum: START, IDLE, HIGH_LS, HIGH_FS, LOW, DONE.
- No sub-module needed. A single FSM plus one counter is sufficient.

Test Plan:
Common setup: W1=W2=32, pWAIT_0_START=8, restart pulsed between tests.
- Early-abort LS: after 10 cycles, drive ls=10 for 10 cycles, then 00; wait 3 cycles → O_speed=AUTO (0).
- LS: after 10 cycles, drive ls=10 for 34 cycles, then 00; wait 3 cycles → O_speed=LS (1), held until restart.
- FS: ls=01 for 34 cycles, then 00 for 31 cycles, then 01; wait 4 cycles → O_speed=FS (2).
- HS: ls=01 for 34 cycles, then 00 for 34 cycles, then 01; wait 4 cycles → O_speed=HS (3).
- Restart/reset: in DONE with HS, pulse I_restart → O_speed=AUTO next cycle and ls ignored for 8 cycles. Assert reset_n low mid HIGH_FS → O_speed=AUTO asynchronously.
- Threshold fallback: I_wait1=0 → the 32-cycle default applies. I_wait1=5 → ls=10 for 5 cycles yields LS.
